pipe_stage: RTL and testbench
=============================

# pipe_stage

Parametrised pipeline stage register: the next generation of the fetch/decode latch, usable between any two pipeline stages. It carries a DATA_W payload plus halt sideband and supports valid/ready flow control with a two-entry skid buffer. It also provides synchronous flush with bubble (NOP) injection, sticky halt blocking, and a saturating back-pressure counter. Instances sit between IF/ID, ID/EX, EX/MEM and MEM/WB with per-stage widths.

## Interface
Parameters:
- DATA_W, 48, payload width (e.g. PC+2, instruction, PC for the IF/ID instance)
- BUBBLE_VAL, {32'h0, 16'h0800}, value driven on out_data when out_valid=0; low 16 bits are the NOP encoding
- CNT_W, 8, width of the stall counter

Ports:
- clk, input, 1, clock; single clock domain
- rst, input, 1, synchronous active-high reset
- in_valid, input, 1, upstream presents an entry
- in_ready, output, 1, stage can accept an entry this cycle
- in_data, input, DATA_W, upstream payload
- in_halt, input, 1, entry carries a halt
- out_valid, output, 1, output entry valid
- out_ready, input, 1, downstream consumes the entry this cycle
- out_data, output, DATA_W, head payload; BUBBLE_VAL when not valid
- out_halt, output, 1, halt bit of head entry; 0 when not valid
- flush, input, 1, discard all held and incoming entries
- stall_cnt, output, CNT_W, cycles with out_valid=1 and out_ready=0, saturating

## Operation
- Handshakes: push = in_valid & in_ready; pop = out_valid & out_ready.
- Storage: main entry (head) and skid entry. Entries are kept in FIFO order, main before skid.
- States are EMPTY, ONE (main full) and TWO (main+skid full). State is encoded in a shared enum.
  - EMPTY: push -> ONE (main <= in).
  - ONE: push&pop -> ONE (main <= in). Push only -> TWO (skid <= in). Pop only -> EMPTY.
  - TWO: pop -> ONE (main <= skid). No pop -> TWO.
- in_ready = (state != TWO) & !halt_seen. It is a function of registered state only; there is no combinational path from out_ready to in_ready.
- out_valid = (state != EMPTY). out_data and out_halt are taken from the main entry, or BUBBLE_VAL/0 in EMPTY.
- Flush: next state is EMPTY regardless of push/pop.
  - Any entry pushed in the flush cycle is discarded.
  - halt_seen is cleared.
  - The stall counter is unaffected.
- Halt:
  - halt_seen is set on a push with in_halt=1.
  - While halt_seen is set, in_ready=0; held entries still drain normally.
  - halt_seen is cleared only by flush or rst.
- Stall counter: increments when out_valid & !out_ready and holds at 2^CNT_W-1. It is cleared only by rst.
- Reset values:
  - state EMPTY, so out_valid=0, out_data=BUBBLE_VAL, out_halt=0.
  - in_ready=1, halt_seen=0, stall_cnt=0.
  - The skid entry contents are don't-care.
- rst has priority over flush, and flush has priority over push/pop.

## Timing
- Latency: an entry pushed in cycle N is on out_data/out_valid in cycle N+1 when the stage was EMPTY, or ONE with a pop.
- Throughput: one entry per cycle with out_ready held high.
- After out_ready deasserts, at most one further push is accepted (into skid); in_ready drops the following cycle.
- After flush in cycle N, out_valid=0 and out_data=BUBBLE_VAL in cycle N+1, and in_ready=1 in N+1.
- Halt push in cycle N gives in_ready=0 from N+1. The halt entry reaches out_halt=1 per normal latency.
- rst asserted mid-transfer takes effect at the next edge, and any held entries are lost.

## Structure
- Shared package pipe_pkg holds:
  - the state enum (EMPTY, ONE, TWO)
  - NOP_INST = 16'h0800
  - the default BUBBLE_VAL construction helper constant
- One sub-module is natural: pipe_entry_reg, a DATA_W+1-bit register with load enable and synchronous reset to a parameter value. It is instantiated twice, once for main and once for skid.
- Control FSM, halt_seen and stall counter live in pipe_stage.

## Test plan
- Reset with out_ready=1, then push 0x1111, 0x2222, 0x3333 on consecutive cycles -> out_data shows them in cycles 1, 2, 3 after each push; in_ready stays 1 throughout.
- Hold out_ready=0 and push 0xAAAA, 0xBBBB -> state TWO and in_ready=0. Raise out_ready -> 0xAAAA then 0xBBBB popped in order with no loss or duplication.
- In TWO, assert flush with in_valid=1, in_data=0xCCCC -> next cycle out_valid=0, out_data=BUBBLE_VAL (low bits 0x0800), and 0xCCCC never appears.
- Push an entry with in_halt=1 -> in_ready=0 the following cycle and stays 0 while the halt entry drains with out_halt=1. Then flush -> in_ready=1.
- Hold out_ready=0 with one valid entry for 300 cycles at CNT_W=8 -> stall_cnt=255 and stays saturated. Flush -> stall_cnt unchanged. rst -> stall_cnt=0.
- Assert rst in ONE while pushing and flushing simultaneously -> next cycle all outputs equal their reset values.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register family: occupancy
// states, NOP encoding and the default bubble payload.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  localparam logic [15:0] NOP_INST = 16'h0800;

  // Default bubble for the 48-bit IF/ID payload: zero PCs, NOP instruction.
  localparam logic [47:0] BUBBLE_DEFAULT = {32'h0, NOP_INST};

endpackage : pipe_pkg

// File: rtl/pipe_entry_reg.sv
// Payload+sideband holding register with load enable and synchronous reset
// to a parameterised value; used for both the main and skid entries.
module pipe_entry_reg #(
  parameter int unsigned  W       = 49,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= RST_VAL;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule : pipe_entry_reg

// File: rtl/pipe_stage.sv
// Pipeline stage register with valid/ready flow control, two-entry skid
// buffer, flush with bubble injection, sticky halt and a stall counter.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W     = 48,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = DATA_W'(BUBBLE_DEFAULT),
  parameter int unsigned       CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_halt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_halt,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int unsigned EW = DATA_W + 1;

  state_e           state_q, state_d;
  logic             halt_seen_q, halt_seen_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [EW-1:0] main_q, skid_q, main_d;
  logic          main_en, skid_en;
  logic          push, pop;

  // in_ready depends only on registered state, never on out_ready.
  assign in_ready  = (state_q != TWO) && !halt_seen_q;
  assign out_valid = (state_q != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_d     = state_q;
    halt_seen_d = halt_seen_q || (push && in_halt);
    main_en     = 1'b0;
    skid_en     = 1'b0;
    main_d      = {in_halt, in_data};
    if (flush) begin
      state_d     = EMPTY;
      halt_seen_d = 1'b0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (push) begin
            state_d = ONE;
            main_en = 1'b1;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_en = 1'b1;
          end else if (push) begin
            state_d = TWO;
            skid_en = 1'b1;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            state_d = ONE;
            main_en = 1'b1;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      halt_seen_q <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      halt_seen_q <= halt_seen_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  pipe_entry_reg #(
    .W       (EW),
    .RST_VAL ({1'b0, BUBBLE_VAL})
  ) u_main (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (main_en),
    .d_i   (main_d),
    .q_o   (main_q)
  );

  pipe_entry_reg #(
    .W       (EW),
    .RST_VAL ({1'b0, BUBBLE_VAL})
  ) u_skid (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (skid_en),
    .d_i   ({in_halt, in_data}),
    .q_o   (skid_q)
  );

  // main_q keeps stale contents after flush/pop, so mask it while empty.
  assign out_data  = out_valid ? main_q[DATA_W-1:0] : BUBBLE_VAL;
  assign out_halt  = out_valid && main_q[DATA_W];
  assign stall_cnt = stall_cnt_q;

endmodule : pipe_stage

// File: tb/tb_pipe_stage.sv
// Self-checking bench for pipe_stage: queue scoreboard plus a small
// occupancy/halt/stall model checked every cycle, directed and random phases.
module tb_pipe_stage;

  localparam int unsigned DW = 48;
  localparam int unsigned CW = 8;
  localparam logic [DW-1:0] BUB = 48'h0000_0000_0800;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, in_halt, out_valid, out_ready;
  logic          out_halt, flush;
  logic [DW-1:0] in_data, out_data;
  logic [CW-1:0] stall_cnt;

  int          total = 0;
  int          bad   = 0;
  logic [DW:0] sb[$];
  bit          halt_m;
  int unsigned cnt_m;

  pipe_stage #(
    .DATA_W (DW),
    .CNT_W  (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_halt   (in_halt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_halt  (out_halt),
    .flush     (flush),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Check outputs against the model mid-cycle, then advance model and clock.
  task automatic step();
    bit mv, mr, pu, po;
    @(negedge clk);
    mv = (sb.size() != 0);
    mr = (sb.size() < 2) && !halt_m;
    check_eq("out_valid", 64'(out_valid), 64'(mv));
    check_eq("in_ready", 64'(in_ready), 64'(mr));
    check_eq("stall_cnt", 64'(stall_cnt), 64'(cnt_m));
    if (mv) begin
      check_eq("out_data", 64'(out_data), 64'(sb[0][DW-1:0]));
      check_eq("out_halt", 64'(out_halt), 64'(sb[0][DW]));
    end else begin
      check_eq("bubble_data", 64'(out_data), 64'(BUB));
      check_eq("bubble_halt", 64'(out_halt), 64'd0);
    end
    pu = in_valid && mr;
    po = mv && out_ready;
    if (rst) begin
      sb.delete();
      halt_m = 0;
      cnt_m  = 0;
    end else begin
      if (mv && !out_ready && cnt_m < 255) cnt_m++;
      if (flush) begin
        sb.delete();
        halt_m = 0;
      end else begin
        if (po) void'(sb.pop_front());
        if (pu) begin
          sb.push_back({in_halt, in_data});
          if (in_halt) halt_m = 1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_valid"}, 64'(out_valid), 64'd0);
    check_eq({tag, "_data"}, 64'(out_data), 64'(BUB));
    check_eq({tag, "_halt"}, 64'(out_halt), 64'd0);
    check_eq({tag, "_ready"}, 64'(in_ready), 64'd1);
    check_eq({tag, "_stall"}, 64'(stall_cnt), 64'd0);
  endtask

  logic [DW-1:0] vals[3];

  initial begin
    rst = 1; in_valid = 0; in_data = '0; in_halt = 0; out_ready = 1; flush = 0;
    halt_m = 0; cnt_m = 0;
    vals[0] = 48'h1111; vals[1] = 48'h2222; vals[2] = 48'h3333;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 0;

    // Back-to-back pushes with one-cycle latency
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_data = vals[i];
      step();
      check_eq("lat_data", 64'(out_data), 64'(vals[i]));
      check_eq("lat_ready", 64'(in_ready), 64'd1);
    end
    in_valid = 0;
    step();
    check_eq("drain1_empty", 64'(sb.size()), 64'd0);

    // Fill skid under back-pressure, then drain in order
    out_ready = 0;
    in_valid = 1; in_data = 48'hAAAA; step();
    in_data = 48'hBBBB; step();
    in_valid = 0;
    check_eq("two_ready", 64'(in_ready), 64'd0);
    step();
    out_ready = 1;
    step();
    check_eq("skid_order", 64'(out_data), 64'hBBBB);
    step();
    check_eq("drain2_valid", 64'(out_valid), 64'd0);

    // Flush in TWO while offering an entry
    out_ready = 0;
    in_valid = 1; in_data = 48'hDDDD; step();
    in_data = 48'hEEEE; step();
    flush = 1; in_data = 48'hCCCC; step();
    flush = 0; in_valid = 0;
    check_eq("flush_valid", 64'(out_valid), 64'd0);
    check_eq("flush_data", 64'(out_data), 64'(BUB));
    check_eq("flush_ready", 64'(in_ready), 64'd1);
    out_ready = 1;
    repeat (3) step();

    // Sticky halt
    out_ready = 0;
    in_valid = 1; in_data = 48'h1234; in_halt = 1; step();
    in_halt = 0; in_data = 48'h5555;
    check_eq("halt_ready", 64'(in_ready), 64'd0);
    check_eq("halt_out", 64'(out_halt), 64'd1);
    repeat (3) step();
    out_ready = 1;
    step();
    step();
    check_eq("halt_drained_ready", 64'(in_ready), 64'd0);
    check_eq("halt_drained_valid", 64'(out_valid), 64'd0);
    flush = 1; step();
    flush = 0; in_valid = 0;
    check_eq("halt_flush_ready", 64'(in_ready), 64'd1);

    // Stall counter saturation
    out_ready = 0;
    in_valid = 1; in_data = 48'h9999; step();
    in_valid = 0;
    repeat (300) step();
    check_eq("stall_sat", 64'(stall_cnt), 64'd255);
    flush = 1; step();
    flush = 0;
    check_eq("stall_flush", 64'(stall_cnt), 64'd255);
    rst = 1; step();
    rst = 0;
    check_eq("stall_rst", 64'(stall_cnt), 64'd0);

    // Reset beats simultaneous push and flush
    out_ready = 1;
    in_valid = 1; in_data = 48'h7777; step();
    out_ready = 0;
    rst = 1; flush = 1; in_data = 48'h8888; step();
    rst = 0; flush = 0; in_valid = 0;
    check_reset_vals("rst_mid");

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = {16'($urandom), 32'($urandom)};
      in_halt   = ($urandom_range(0, 15) == 0);
      flush     = ($urandom_range(0, 19) == 0);
      step();
    end
    in_valid = 0; in_halt = 0; flush = 0; out_ready = 1;
    repeat (3) step();
    check_eq("final_empty", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pipe_stage
